phys_reg_free_list: RTL
=======================

# phys_reg_free_list

Circular free list of physical register tags for the rename stage, directly upstream of the multiported physical register file. Supplies up to ALLOC_PORTS fresh tags per cycle to rename, which uses them as register file write addresses. Takes back up to FREE_PORTS tags per cycle from commit when superseded mappings retire. On reset, tags 0..ARCH_COUNT-1 are treated as the initial architectural mappings; all remaining tags are free.

## Interface
- PHYS_COUNT, 128, number of physical registers
- ARCH_COUNT, 32, number of architectural registers (permanently mapped)
- TAG_WIDTH, $clog2(PHYS_COUNT), physical tag width (derived, not overridden)
- ALLOC_PORTS, 4, allocation ports per cycle
- FREE_PORTS, 4, free (return) ports per cycle
- DEPTH, PHYS_COUNT-ARCH_COUNT, list capacity (derived)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clk_en  in  1  global stall; when low, no state changes
- alloc_req  in  ALLOC_PORTS  per-port allocation request
- alloc_ready  out  1  high when free_count >= ALLOC_PORTS
- alloc_tag  out  ALLOC_PORTS x TAG_WIDTH  tag granted to each port
- free_en  in  FREE_PORTS  per-port tag return
- free_tag  in  FREE_PORTS x TAG_WIDTH  returned tag
- free_count  out  $clog2(DEPTH+1)  current number of free tags
- overflow_err  out  1  sticky error flag

## Operation
- Storage: DEPTH-entry circular array with a head pointer (read), a tail pointer (write) and a count. Both pointers wrap explicitly at DEPTH-1 to 0, because DEPTH need not be a power of two.
- Reset state:
  - entry k = ARCH_COUNT+k
  - head = 0, tail = 0 (list full)
  - count = DEPTH
  - overflow_err = 0
- Allocation is all-or-nothing. A grant happens only when alloc_ready && clk_en.
  - Requests are compacted by port index. Port i gets entry head+n, where n is the number of set alloc_req bits below i (modulo DEPTH).
  - Head advances by popcount(alloc_req).
  - alloc_tag[i] for a non-requesting port is don't-care.
  - alloc_req while alloc_ready is low: ignored, no state change.
- Free: when clk_en, set free_en ports write free_tag into tail+n, compacted the same way. Tail advances by popcount(free_en).
- Simultaneous alloc and free: next count = count + frees − grants.
  - No bypass. A tag freed in cycle N is allocatable no earlier than cycle N+1.
- Overflow (count + frees − grants > DEPTH):
  - overflow_err sets and stays set until reset.
  - Excess writes are dropped, and count saturates at DEPTH.
  - This never occurs in correct operation; the bench asserts on it.
- Returning a tag below ARCH_COUNT is legal. Rename retargets architectural slots freely.

## Timing
- alloc_tag, alloc_ready and free_count are combinational from registered head, count and array. No input-to-output paths.
- Pointer, count and array updates take effect on the rising edge following the request. Allocation is a 0-cycle grant, with state update at the next edge.
- Asynchronous rst restores the reset state immediately, including mid-operation; any in-flight grant is lost.
- With clk_en low, inputs are ignored and outputs hold.

## Structure
- Shared rename package holds:
  - typedef phys_tag_t (TAG_WIDTH bits)
  - PHYS_COUNT and ARCH_COUNT constants, which the register file also uses
- Sub-module popcount_prefix: computes per-port exclusive prefix counts and the total from a request vector. It is instantiated twice, once for alloc and once for free.
- Array writes use modulo-DEPTH address adders. The array is flops, not RAM, because of the multiple write ports.

## Test plan
- Reset then idle: free_count=96, alloc_ready=1. alloc_tag = 32, 33, 34, 35 with all four ports requesting.
- alloc_req=4'b1010 at reset: port1 gets 32 and port3 gets 33. Next cycle free_count=94 and alloc_tag[0]=34.
- Drain: 24 cycles of 4'b1111 reach free_count=0 and alloc_ready=0. Further alloc_req causes no change.
- Wrap: from empty, free 4 tags {5,9,2,7} per cycle while allocating 4. Run past entry 95 → tags come out in freed order, and pointers wrap 95→0.
- Simultaneous events: at count=3, 4'b1111 requested with 2 frees → no grant (alloc_ready=0), and count becomes 5. Also check that a tag freed in cycle N is not granted in cycle N.
- Errors and reset: free 4 tags while full → overflow_err=1 and count stays 96. Assert rst mid-burst → immediate return to reset values with overflow_err=0.

Source files
------------

// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename definitions: register-file sizing, the physical tag type and
// a modulo index helper for circular structures whose depth is not a power of two.
package phys_reg_free_list_pkg;

   localparam int PHYS_COUNT = 128;
   localparam int ARCH_COUNT = 32;
   localparam int TAG_WIDTH  = $clog2(PHYS_COUNT);

   typedef logic [TAG_WIDTH-1:0] phys_tag_t;

   // Callers keep off below depth, so one conditional subtract is enough.
   function automatic int unsigned wrap_idx(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned depth);
      int unsigned sum;
      sum = base + off;
      return (sum >= depth) ? sum - depth : sum;
   endfunction

endpackage

// File: rtl/phys_reg_free_list_popcount.sv
// Exclusive prefix popcount of a request vector: port i sees how many lower
// ports are set, which is its compacted slot offset; total is the full popcount.
module popcount_prefix #(
   parameter int N  = 4,
   parameter int CW = $clog2(N+1)
) (
   input  logic [N-1:0]         req,
   output logic [N-1:0][CW-1:0] prefix,
   output logic [CW-1:0]        total
);

   logic [CW-1:0] acc;

   always_comb begin
      acc    = '0;
      prefix = '0;
      for (int i = 0; i < N; i++) begin
         prefix[i] = acc;
         acc       = acc + CW'(req[i]);
      end
      total = acc;
   end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: compacted multi-port grant at
// the head, compacted multi-port return at the tail, sticky overflow detection.
module phys_reg_free_list #(
   parameter int PHYS_COUNT  = phys_reg_free_list_pkg::PHYS_COUNT,
   parameter int ARCH_COUNT  = phys_reg_free_list_pkg::ARCH_COUNT,
   parameter int ALLOC_PORTS = 4,
   parameter int FREE_PORTS  = 4,
   localparam int TAG_WIDTH  = $clog2(PHYS_COUNT),
   localparam int DEPTH      = PHYS_COUNT - ARCH_COUNT,
   localparam int CNT_W      = $clog2(DEPTH+1)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  clk_en,
   input  logic [ALLOC_PORTS-1:0]                alloc_req,
   output logic                                  alloc_ready,
   output logic [ALLOC_PORTS-1:0][TAG_WIDTH-1:0] alloc_tag,
   input  logic [FREE_PORTS-1:0]                 free_en,
   input  logic [FREE_PORTS-1:0][TAG_WIDTH-1:0]  free_tag,
   output logic [CNT_W-1:0]                      free_count,
   output logic                                  overflow_err
);

   import phys_reg_free_list_pkg::*;

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AW    = $clog2(ALLOC_PORTS+1);
   localparam int FW    = $clog2(FREE_PORTS+1);
   localparam int SW    = CNT_W + 1;

   logic [TAG_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     head, tail, head_nxt, tail_nxt;
   logic [CNT_W-1:0]     count, count_nxt;
   logic                 ovf, overflow_now;

   logic [ALLOC_PORTS-1:0][AW-1:0] alloc_pre;
   logic [AW-1:0]                  alloc_total;
   logic [FREE_PORTS-1:0][FW-1:0]  free_pre;
   logic [FW-1:0]                  free_total;
   logic [SW-1:0]                  grants, frees, space, written;

   popcount_prefix #(.N(ALLOC_PORTS), .CW(AW)) u_alloc_pc (
      .req    (alloc_req),
      .prefix (alloc_pre),
      .total  (alloc_total)
   );

   popcount_prefix #(.N(FREE_PORTS), .CW(FW)) u_free_pc (
      .req    (free_en),
      .prefix (free_pre),
      .total  (free_total)
   );

   always_comb begin
      alloc_ready = (count >= CNT_W'(ALLOC_PORTS));
      for (int i = 0; i < ALLOC_PORTS; i++)
         alloc_tag[i] = mem[PTR_W'(wrap_idx(32'(head), 32'(alloc_pre[i]), DEPTH))];
   end

   // Space left after this cycle's grants bounds how many returns are kept.
   always_comb begin
      grants       = (clk_en && alloc_ready) ? SW'(alloc_total) : '0;
      frees        = SW'(free_total);
      space        = SW'(DEPTH) - SW'(count) + grants;
      overflow_now = clk_en && (frees > space);
      written      = (frees > space) ? space : frees;
      count_nxt    = CNT_W'(SW'(count) + written - grants);
      head_nxt     = PTR_W'(wrap_idx(32'(head), 32'(grants), DEPTH));
      tail_nxt     = PTR_W'(wrap_idx(32'(tail), 32'(written), DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= CNT_W'(DEPTH);
         ovf   <= 1'b0;
         for (int k = 0; k < DEPTH; k++)
            mem[k] <= TAG_WIDTH'(ARCH_COUNT + k);
      end else if (clk_en) begin
         head  <= head_nxt;
         tail  <= tail_nxt;
         count <= count_nxt;
         ovf   <= ovf | overflow_now;
         for (int j = 0; j < FREE_PORTS; j++)
            if (free_en[j] && (SW'(free_pre[j]) < space))
               mem[PTR_W'(wrap_idx(32'(tail), 32'(free_pre[j]), DEPTH))] <= free_tag[j];
      end
   end

   assign free_count   = count;
   assign overflow_err = ovf;

endmodule
